uart_rx: RTL and testbench

- Receive-side counterpart of the team's UART transmitter: deserialises an 8N1 serial line (idle high, start 0, 8 data bits LSB first, stop 1) into bytes.
- Sits directly downstream of the transmitter's tx pin in loopback, or on the board RX pin.
- Oversamples with the system clock, validates start and stop bits, and presents each byte through a valid/ack holding register with overrun and framing-error reporting.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop synchroniser, mid-bit sampling
// and a valid/ack holding register reporting overrun and framing errors.
module uart_rx #(
  parameter int CLKS_PER_BIT = 435,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bitidx_q, bitidx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            commit;

  always_comb begin
    state_d     = state_q;
    sync1_d     = rx;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    cnt_d       = cnt_q;
    bitidx_d    = bitidx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    commit      = 1'b0;

    case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CW'(HALF_BIT - 1)) begin
          cnt_d = '0;
          // a line already back high at mid-start is treated as a glitch
          if (sync2_q) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            bitidx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          shift_d  = {sync2_q, shift_q[7:1]};
          cnt_d    = '0;
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (sync2_q) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BRK: begin
        if (sync2_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // holding register: a same-cycle ack frees the slot for the new byte
    if (commit) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
        overrun_d  = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      bitidx_q    <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      bitidx_q    <= bitidx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: vector table, corner
// sequences, and randomized frames against a byte-level handshake model.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int CPB2 = 435;

  logic       clk;
  logic       reset;
  logic       rx, rx2;
  logic       rx_ack, rx_ack2;
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, rx_valid2;
  logic       overrun, overrun2;
  logic       frame_err, frame_err2;
  logic       busy, busy2;

  int n_chk = 0;
  int n_err = 0;
  int fe_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .overrun(overrun), .frame_err(frame_err), .busy(busy)
  );

  uart_rx #(.CLKS_PER_BIT(CPB2)) u_dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ack(rx_ack2), .overrun(overrun2), .frame_err(frame_err2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  function automatic int lat(input int cpb);
    return 3 + cpb / 2 + 9 * cpb;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  // Drives one 8N1 frame, one line change per negedge; returns the cycle index
  // at which the selected rx_valid was first seen high (-1 if never).
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int cpb,
                            input int ack_at, input int reset_at, input int hold,
                            input bit line2, output int first_valid);
    logic v;
    logic val;
    int   idx;
    first_valid = -1;
    for (int t = 0; t < 10 * cpb + hold; t++) begin
      @(negedge clk);
      v = line2 ? rx_valid2 : rx_valid;
      if (v && first_valid < 0) first_valid = t;
      if (reset_at >= 0 && t == reset_at + 1) begin
        chk("rst_mid_data", {24'd0, rx_data}, 32'h00);
        chk("rst_mid_valid", rx_valid, 0);
        chk("rst_mid_ovr", overrun, 0);
        chk("rst_mid_fe", frame_err, 0);
        chk("rst_mid_busy", busy, 0);
      end
      idx = t / cpb;
      if (idx == 0)      val = 1'b0;
      else if (idx <= 8) val = d[idx-1];
      else if (idx == 9) val = stop_ok;
      else               val = 1'b0;
      if (line2) rx2 = val;
      else       rx  = val;
      rx_ack = (t == ack_at);
      reset  = (t == reset_at);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         ack;
    int         hold;
    bit         chk_lat;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovr;
    int         exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int fv, fe0, bcnt;
    logic       mv, mo;
    logic [7:0] md, d;
    bit         ok, pre_v;
    int         hold, mfe;

    vecs[0] = '{8'hA5, 1, 1, 0,  1, 1'b1, 8'hA5, 1'b0, 0};
    vecs[1] = '{8'h3C, 1, 1, 0,  1, 1'b1, 8'h3C, 1'b0, 0};
    vecs[2] = '{8'hC3, 1, 1, 0,  1, 1'b1, 8'hC3, 1'b0, 0};
    vecs[3] = '{8'h11, 1, 0, 0,  1, 1'b1, 8'h11, 1'b0, 0};
    vecs[4] = '{8'h22, 1, 1, 0,  0, 1'b1, 8'h11, 1'b1, 0};
    vecs[5] = '{8'h55, 0, 0, 40, 0, 1'b0, 8'h11, 1'b0, 1};
    vecs[6] = '{8'h5A, 1, 1, 0,  1, 1'b1, 8'h5A, 1'b0, 0};

    reset = 1'b1; rx = 1'b1; rx2 = 1'b1; rx_ack = 1'b0; rx_ack2 = 1'b0;
    cycles(3);
    chk("reset_data", {24'd0, rx_data}, 32'h00);
    chk("reset_valid", rx_valid, 0);
    chk("reset_ovr", overrun, 0);
    chk("reset_fe", frame_err, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    cycles(4);

    foreach (vecs[i]) begin
      fe0 = fe_cnt;
      send_frame(vecs[i].data, vecs[i].stop_ok, CPB, -1, -1, vecs[i].hold, 0, fv);
      if (vecs[i].hold > 0) chk($sformatf("v%0d_break_busy", i), busy, 1);
      rx = 1'b1;
      cycles(6);
      chk($sformatf("v%0d_valid", i), rx_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
      chk($sformatf("v%0d_ovr", i), overrun, vecs[i].exp_ovr);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
      if (vecs[i].chk_lat) chk($sformatf("v%0d_latency", i), fv, lat(CPB));
      if (vecs[i].ack) begin
        pulse_ack();
        chk($sformatf("v%0d_ack_valid", i), rx_valid, 0);
        chk($sformatf("v%0d_ack_ovr", i), overrun, 0);
      end
    end

    fe0 = fe_cnt;
    bcnt = 0;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      if (busy) bcnt++;
      rx = (t < 4) ? 1'b0 : 1'b1;
    end
    chk("glitch_busy_cycles", bcnt, 8);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);

    send_frame(8'h01, 1, CPB, -1, -1, 0, 0, fv);
    cycles(3);
    send_frame(8'h02, 1, CPB, -1, -1, 0, 0, fv);
    cycles(3);
    chk("ovr_setup_data", {24'd0, rx_data}, 32'h01);
    chk("ovr_setup_ovr", overrun, 1);
    send_frame(8'h03, 1, CPB, lat(CPB) - 1, -1, 0, 0, fv);
    cycles(3);
    chk("same_cycle_valid", rx_valid, 1);
    chk("same_cycle_data", {24'd0, rx_data}, 32'h03);
    chk("same_cycle_ovr", overrun, 0);
    pulse_ack();

    mv = 1'b0; mo = 1'b0; md = 8'h03; mfe = 0; fe0 = fe_cnt;
    for (int n = 0; n < 20; n++) begin
      d     = 8'($urandom);
      ok    = ($urandom_range(0, 9) != 0);
      hold  = ok ? 0 : int'($urandom_range(0, 30));
      pre_v = mv;
      send_frame(d, ok, CPB, -1, -1, hold, 0, fv);
      rx = 1'b1;
      cycles(6 + int'($urandom_range(0, 5)));
      if (ok) begin
        if (!mv) begin md = d; mv = 1'b1; end
        else mo = 1'b1;
      end else begin
        mfe++;
      end
      chk("rnd_valid", rx_valid, mv);
      chk("rnd_data", {24'd0, rx_data}, {24'd0, md});
      chk("rnd_ovr", overrun, mo);
      chk("rnd_fe_count", fe_cnt - fe0, mfe);
      if (ok && !pre_v) chk("rnd_latency", fv, lat(CPB));
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        mv = 1'b0; mo = 1'b0;
        chk("rnd_ack_valid", rx_valid, 0);
        chk("rnd_ack_ovr", overrun, 0);
      end
    end
    if (mv) pulse_ack();

    send_frame(8'h00, 1, CPB2, -1, -1, 0, 1, fv);
    cycles(3);
    chk("lb_00_valid", rx_valid2, 1);
    chk("lb_00_data", {24'd0, rx_data2}, 32'h00);
    chk("lb_00_latency", fv, lat(CPB2));
    @(negedge clk); rx_ack2 = 1'b1; @(negedge clk); rx_ack2 = 1'b0;
    send_frame(8'hFF, 1, CPB2, -1, -1, 0, 1, fv);
    cycles(3);
    chk("lb_ff_valid", rx_valid2, 1);
    chk("lb_ff_data", {24'd0, rx_data2}, 32'hFF);
    chk("lb_ff_latency", fv, lat(CPB2));
    chk("lb_ovr", overrun2, 0);
    chk("lb_fe", frame_err2, 0);
    @(negedge clk); rx_ack2 = 1'b1; @(negedge clk); rx_ack2 = 1'b0;
    @(negedge clk);
    chk("lb_ack_valid", rx_valid2, 0);
    chk("lb_busy", busy2, 0);

    send_frame(8'h7E, 1, CPB, -1, -1, 0, 0, fv);
    cycles(3);
    send_frame(8'h81, 1, CPB, -1, -1, 0, 0, fv);
    cycles(3);
    chk("pre_rst_valid", rx_valid, 1);
    chk("pre_rst_ovr", overrun, 1);
    send_frame(8'hF5, 1, CPB, -1, 5 * CPB + CPB / 2, 0, 0, fv);
    rx = 1'b1;
    cycles(40);
    chk("post_rst_valid", rx_valid, 0);
    chk("post_rst_data", {24'd0, rx_data}, 32'h00);
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
